// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle control FSM: opcode map, state encoding, opcode classes.
// Latency: none (declarations only).
// Backpressure: n/a.
package multicycle_control_pkg;

  localparam int PKG_OPCODE_W = 5;

  // Opcode map; 22..31 are undefined and trap as illegal
  localparam logic [4:0] OP_LW_1 = 5'd0;
  localparam logic [4:0] OP_LW_2 = 5'd1;
  localparam logic [4:0] OP_LW_3 = 5'd2;
  localparam logic [4:0] OP_SW_1 = 5'd3;
  localparam logic [4:0] OP_SW_2 = 5'd4;
  localparam logic [4:0] OP_MOV  = 5'd5;
  localparam logic [4:0] OP_ADD  = 5'd6;
  localparam logic [4:0] OP_SUB  = 5'd7;
  localparam logic [4:0] OP_MUL  = 5'd8;
  localparam logic [4:0] OP_DIV  = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_OR   = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_SHR  = 5'd14;
  localparam logic [4:0] OP_CMP  = 5'd15;
  localparam logic [4:0] OP_JR   = 5'd16;
  localparam logic [4:0] OP_JPC  = 5'd17;
  localparam logic [4:0] OP_BRFL = 5'd18;
  localparam logic [4:0] OP_CALL = 5'd19;
  localparam logic [4:0] OP_RET  = 5'd20;
  localparam logic [4:0] OP_NOP  = 5'd21;

  // ALUOp presented while an undefined opcode is in DECODE
  localparam logic [4:0] ILLEGAL_ALUOP = 5'b11111;

  // Phase encoding, kept as plain constants so state_o stays a stable debug encoding
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  typedef enum logic [3:0] {
    CL_NOP, CL_LOAD, CL_STORE, CL_ALU, CL_CMP,
    CL_MULDIV, CL_JUMP, CL_COND, CL_CALL, CL_ILLEGAL
  } op_class_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the instruction source / datapath and the multi-cycle control FSM.
// Latency: none (wires only).
// Backpressure: instr_ready/instr_valid handshake; mem_ready and alu_done stretch MEM/EXEC.
interface multicycle_control_if #(
  parameter int OPCODE_W = multicycle_control_pkg::PKG_OPCODE_W,
  parameter int ALUOP_W  = 5,
  parameter int CNT_W    = 16
);
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                instr_ready;
  logic                mem_ready;
  logic                alu_done;
  logic                flag_taken;
  logic                ir_write;
  logic                pc_write;
  logic                RegDst;
  logic                ALUSrc;
  logic                MemToReg;
  logic                RegWrite;
  logic                MemRead;
  logic                MemWrite;
  logic                Branch;
  logic [ALUOP_W-1:0]  ALUOp;
  logic                alu_start;
  logic                illegal;
  logic [CNT_W-1:0]    retired;
  logic [2:0]          state_o;

  // Controller side
  modport slave (
    input  instr_valid, opcode, mem_ready, alu_done, flag_taken,
    output instr_ready, ir_write, pc_write, RegDst, ALUSrc, MemToReg, RegWrite,
           MemRead, MemWrite, Branch, ALUOp, alu_start, illegal, retired, state_o
  );

  // Instruction source / datapath side
  modport master (
    output instr_valid, opcode, mem_ready, alu_done, flag_taken,
    input  instr_ready, ir_write, pc_write, RegDst, ALUSrc, MemToReg, RegWrite,
           MemRead, MemWrite, Branch, ALUOp, alu_start, illegal, retired, state_o
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier feeding the control FSM.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module multicycle_control_decode
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = PKG_OPCODE_W
) (
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_e           op_class,
  output logic                is_load,
  output logic                is_store,
  output logic                is_muldiv,
  output logic                is_cond_branch,
  output logic                legal
);

  // Map every opcode onto its execution class; anything unlisted is illegal
  always_comb begin
    op_class = CL_ILLEGAL;
    case (opcode)
      OP_LW_1, OP_LW_2, OP_LW_3:                 op_class = CL_LOAD;
      OP_SW_1, OP_SW_2:                          op_class = CL_STORE;
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_NOT, OP_SHL, OP_SHR:                    op_class = CL_ALU;
      OP_CMP:                                    op_class = CL_CMP;
      OP_MUL, OP_DIV:                            op_class = CL_MULDIV;
      OP_JR, OP_RET:                             op_class = CL_JUMP;
      OP_JPC, OP_BRFL:                           op_class = CL_COND;
      OP_CALL:                                   op_class = CL_CALL;
      OP_NOP:                                    op_class = CL_NOP;
      default:                                   op_class = CL_ILLEGAL;
    endcase
  end

  assign is_load        = (op_class == CL_LOAD);
  assign is_store       = (op_class == CL_STORE);
  assign is_muldiv      = (op_class == CL_MULDIV);
  assign is_cond_branch = (op_class == CL_COND);
  assign legal          = (op_class != CL_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// Phase-sequenced FETCH/DECODE/EXEC/MEM/WB control FSM driving datapath strobes per phase.
// Latency: NOP 2, branch 3, ALU/SW 4, LW 5 cycles plus any mem_ready / alu_done wait cycles.
// Backpressure: instr_ready only in FETCH; MEM holds until mem_ready, MUL/DIV EXEC until alu_done.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int OPCODE_W = PKG_OPCODE_W,
  parameter int ALUOP_W  = 5,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  multicycle_control_if.slave bus
);

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    ret_q;
  logic                retire;

  op_class_e op_class;
  logic      is_load, is_store, is_muldiv, is_cond_branch, legal;

  logic               instr_ready, ir_write, pc_write, reg_dst, alu_src, mem_to_reg;
  logic               reg_write, mem_read, mem_write, branch, alu_start, illegal;
  logic [ALUOP_W-1:0] alu_op;
  logic [ALUOP_W-1:0] op_ext;

  // Classify the latched opcode, so decode is stable for the whole instruction
  multicycle_control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode         (op_q),
    .op_class       (op_class),
    .is_load        (is_load),
    .is_store       (is_store),
    .is_muldiv      (is_muldiv),
    .is_cond_branch (is_cond_branch),
    .legal          (legal)
  );

  assign op_ext = ALUOP_W'(op_q);

  // Next-state and per-phase control decode; every strobe defaults low
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    instr_ready = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    branch      = 1'b0;
    alu_start   = 1'b0;
    illegal     = 1'b0;
    alu_op      = '0;
    case (state_q)
      ST_FETCH: begin
        // reset forces the FSM here, so gating by rst_n keeps all outputs low in reset
        instr_ready = rst_n;
        if (bus.instr_valid && rst_n) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_op = op_ext;
        if (!legal) begin
          illegal = 1'b1;
          alu_op  = '1;
          state_d = ST_FETCH;
        end else if (op_class == CL_NOP) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          alu_start = is_muldiv;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        alu_op = op_ext;
        if (is_load || is_store) begin
          // LW_2 / SW_2 take the address from a register, the others from the immediate
          alu_src = (op_q != OP_LW_2) && (op_q != OP_SW_2);
          state_d = ST_MEM;
        end else if (is_muldiv) begin
          if (bus.alu_done) state_d = ST_WB;
        end else if (is_cond_branch) begin
          branch   = 1'b1;
          pc_write = bus.flag_taken;
          retire   = 1'b1;
          state_d  = ST_FETCH;
        end else begin
          case (op_class)
            CL_ALU: begin
              reg_dst = 1'b1;
              state_d = ST_WB;
            end
            CL_CMP: begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CL_JUMP: begin
              branch   = 1'b1;
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = ST_FETCH;
            end
            CL_CALL: begin
              branch   = 1'b1;
              pc_write = 1'b1;
              state_d  = ST_WB;
            end
            default: state_d = ST_FETCH;
          endcase
        end
      end
      ST_MEM: begin
        mem_read  = is_load;
        mem_write = is_store;
        if (bus.mem_ready) begin
          state_d = is_load ? ST_WB : ST_FETCH;
          retire  = !is_load;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        reg_dst    = (op_class == CL_ALU) || is_muldiv;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Phase register; async reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  // Opcode latch, loaded only on an accepted fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       op_q <= OPCODE_W'(OP_NOP);
    else if (state_q == ST_FETCH && bus.instr_valid)  op_q <= bus.opcode;
  end

  // Saturating retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ret_q <= '0;
    else if (retire && ret_q != '1) ret_q <= ret_q + 1'b1;
  end

  assign bus.instr_ready = instr_ready;
  assign bus.ir_write    = ir_write;
  assign bus.pc_write    = pc_write;
  assign bus.RegDst      = reg_dst;
  assign bus.ALUSrc      = alu_src;
  assign bus.MemToReg    = mem_to_reg;
  assign bus.RegWrite    = reg_write;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.Branch      = branch;
  assign bus.ALUOp       = alu_op;
  assign bus.alu_start   = alu_start;
  assign bus.illegal     = illegal;
  assign bus.retired     = ret_q;
  assign bus.state_o     = state_q;

endmodule
